// File: rtl/deflect_port_allocator_pkg.sv
// rtl/deflect_port_allocator_pkg.sv - shared constants, types and helpers for the deflection port allocator
package deflect_port_allocator_pkg;

  localparam int PORT_W     = 0;
  localparam int PORT_E     = 1;
  localparam int PORT_S     = 2;
  localparam int PORT_N     = 3;
  localparam int PORT_LOCAL = 4;
  localparam int NUM_PORT   = 5;
  localparam int NUM_IN     = 4;

  localparam int FLIT_DATA_W = 32;
  localparam int FLIT_AGE_W  = 6;
  localparam int DEFL_CNT_W  = 16;

  // Source tag for an output port: 0..3 network inputs, 4 the local injection flit
  localparam logic [2:0] SRC_INJ = 3'd4;

  typedef struct packed {
    logic [2:0] port;
    logic       defl;
  } pick_t;

  // age + 1, saturating at the largest value a width-bit field can hold
  function automatic int unsigned ageSatInc(input int unsigned age, input int width);
    int unsigned maxAge;
    maxAge = (32'd1 << width) - 32'd1;
    return (age >= maxAge) ? maxAge : age + 32'd1;
  endfunction

  // Eject if allowed, else lowest free productive network port, else lowest free network port.
  // The caller guarantees at least one network port is still free.
  function automatic pick_t pickPort(input logic [4:0] prod, input logic [4:0] freeMask);
    pick_t       p;
    logic [3:0]  cand;
    p    = '0;
    cand = prod[3:0] & freeMask[3:0];
    if (prod[PORT_LOCAL] && freeMask[PORT_LOCAL]) begin
      p.port = 3'(PORT_LOCAL);
    end else if (cand != 4'b0000) begin
      for (int j = 3; j >= 0; j--) if (cand[j]) p.port = 3'(j);
    end else begin
      p.defl = 1'b1;
      for (int j = 3; j >= 0; j--) if (freeMask[j]) p.port = 3'(j);
    end
    return p;
  endfunction

endpackage

// File: rtl/deflect_port_allocator_if.sv
// rtl/deflect_port_allocator_if.sv - flit input, injection and registered output bundle
interface deflect_port_allocator_if #(
  parameter int DATA_W = 32,
  parameter int AGE_W  = 6,
  parameter int CNT_W  = 16
);
  logic [3:0]          in_valid;
  logic [4*AGE_W-1:0]  in_age;
  logic [4*5-1:0]      in_prod;
  logic [4*DATA_W-1:0] in_data;
  logic                inj_req;
  logic [4:0]          inj_prod;
  logic [DATA_W-1:0]   inj_data;
  logic                inj_ack;
  logic [4:0]          out_valid;
  logic [5*AGE_W-1:0]  out_age;
  logic [5*DATA_W-1:0] out_data;
  logic [3:0]          out_deflect;
  logic [CNT_W-1:0]    defl_cnt;
  logic                defl_clr;

  modport master (
    output in_valid, in_age, in_prod, in_data, inj_req, inj_prod, inj_data, defl_clr,
    input  inj_ack, out_valid, out_age, out_data, out_deflect, defl_cnt
  );

  modport slave (
    input  in_valid, in_age, in_prod, in_data, inj_req, inj_prod, inj_data, defl_clr,
    output inj_ack, out_valid, out_age, out_data, out_deflect, defl_cnt
  );
endinterface

// File: rtl/deflect_port_allocator_age_rank_sorter.sv
// rtl/deflect_port_allocator_age_rank_sorter.sv - oldest-first rank order of the four input flits
module age_rank_sorter #(
  parameter int AGE_W = 6
) (
  input  logic [3:0]            valid,
  input  logic [3:0][AGE_W-1:0] age,
  input  logic [1:0]            rrPtr,
  output logic [3:0][1:0]       order
);

  logic [3:0][2:0] rankPos;
  logic [3:0][1:0] rotIdx;
  logic            jWins;

  // Each flit's rank is the number of flits beating it: valid first, older first, then rotated index
  always_comb begin
    rankPos = '0;
    order   = '0;
    jWins   = 1'b0;
    for (int i = 0; i < 4; i++) rotIdx[i] = 2'(i) - rrPtr;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j != i) begin
          if (valid[j] != valid[i])    jWins = valid[j];
          else if (age[j] != age[i])   jWins = (age[j] > age[i]);
          else                         jWins = (rotIdx[j] < rotIdx[i]);
          if (jWins) rankPos[i] = rankPos[i] + 3'd1;
        end
      end
    end
    for (int i = 0; i < 4; i++) order[rankPos[i][1:0]] = 2'(i);
  end

endmodule

// File: rtl/deflect_port_allocator.sv
// rtl/deflect_port_allocator.sv - oldest-first output port allocation with deflection, one registered stage
module deflect_port_allocator
  import deflect_port_allocator_pkg::*;
#(
  parameter int DATA_W = FLIT_DATA_W,
  parameter int AGE_W  = FLIT_AGE_W,
  parameter int CNT_W  = DEFL_CNT_W
) (
  input logic clk,
  input logic rst_n,
  deflect_port_allocator_if.slave bus
);

  logic [3:0][AGE_W-1:0]          ageIn;
  logic [3:0][4:0]                prodIn;
  logic [3:0][DATA_W-1:0]         dataIn;
  logic [3:0][1:0]                rankOrder;
  logic [1:0]                     rrPtr;
  logic [NUM_PORT-1:0]            freeMask;
  logic [NUM_PORT-1:0]            portHit;
  logic [NUM_PORT-1:0][2:0]       portSrc;
  logic [3:0]                     portDefl;
  pick_t                          pick;
  logic                           injAck;
  logic [NUM_PORT-1:0][AGE_W-1:0] nxtAge;
  logic [NUM_PORT-1:0][DATA_W-1:0] nxtData;
  logic [2:0]                     deflPop;
  logic [2:0]                     validPop;
  logic [CNT_W:0]                 cntSum;
  logic [NUM_PORT-1:0]            outValidQ;
  logic [NUM_PORT-1:0][AGE_W-1:0] outAgeQ;
  logic [NUM_PORT-1:0][DATA_W-1:0] outDataQ;
  logic [3:0]                     outDeflQ;
  logic [CNT_W-1:0]               deflCntQ;

  // Split the flat input buses into per-flit fields
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ageIn[i]  = bus.in_age[i*AGE_W +: AGE_W];
      prodIn[i] = bus.in_prod[i*5 +: 5];
      dataIn[i] = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  age_rank_sorter #(.AGE_W(AGE_W)) uSorter (
    .valid (bus.in_valid),
    .age   (ageIn),
    .rrPtr (rrPtr),
    .order (rankOrder)
  );

  // Walk flits in rank order against the free-port mask; injection goes last so it never displaces a flit
  always_comb begin
    freeMask = '1;
    portHit  = '0;
    portSrc  = '0;
    portDefl = '0;
    pick     = '0;
    injAck   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.in_valid[rankOrder[k]]) begin
        pick                = pickPort(prodIn[rankOrder[k]], freeMask);
        freeMask[pick.port] = 1'b0;
        portHit[pick.port]  = 1'b1;
        portSrc[pick.port]  = {1'b0, rankOrder[k]};
        if (pick.defl) portDefl[pick.port[1:0]] = 1'b1;
      end
    end
    injAck = rst_n && bus.inj_req && (freeMask[3:0] != 4'b0000);
    if (injAck) begin
      pick                = pickPort(bus.inj_prod, freeMask);
      freeMask[pick.port] = 1'b0;
      portHit[pick.port]  = 1'b1;
      portSrc[pick.port]  = SRC_INJ;
      if (pick.defl) portDefl[pick.port[1:0]] = 1'b1;
    end
  end

  // Select age (incremented, saturating) and payload for every port that won a flit
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      nxtAge[p]  = '0;
      nxtData[p] = '0;
      if (portHit[p]) begin
        if (portSrc[p] == SRC_INJ) begin
          nxtAge[p]  = AGE_W'(ageSatInc(32'd0, AGE_W));
          nxtData[p] = bus.inj_data;
        end else begin
          nxtAge[p]  = AGE_W'(ageSatInc(32'(ageIn[portSrc[p][1:0]]), AGE_W));
          nxtData[p] = dataIn[portSrc[p][1:0]];
        end
      end
    end
  end

  // Count deflections and valid inputs this cycle, and form the unsaturated counter sum
  always_comb begin
    deflPop  = '0;
    validPop = '0;
    for (int j = 0; j < 4; j++) begin
      deflPop  = deflPop + 3'(portDefl[j]);
      validPop = validPop + 3'(bus.in_valid[j]);
    end
    cntSum = {1'b0, deflCntQ} + (CNT_W+1)'(deflPop);
  end

  // Output stage, tie pointer and saturating deflection counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidQ <= '0;
      outAgeQ   <= '0;
      outDataQ  <= '0;
      outDeflQ  <= '0;
      deflCntQ  <= '0;
      rrPtr     <= '0;
    end else begin
      outValidQ <= portHit;
      outAgeQ   <= nxtAge;
      outDataQ  <= nxtData;
      outDeflQ  <= portDefl;
      if (validPop >= 3'd2) rrPtr <= rrPtr + 2'd1;
      if (bus.defl_clr)      deflCntQ <= '0;
      else if (cntSum[CNT_W]) deflCntQ <= '1;
      else                   deflCntQ <= cntSum[CNT_W-1:0];
    end
  end

  assign bus.inj_ack     = injAck;
  assign bus.out_valid   = outValidQ;
  assign bus.out_age     = outAgeQ;
  assign bus.out_data    = outDataQ;
  assign bus.out_deflect = outDeflQ;
  assign bus.defl_cnt    = deflCntQ;

endmodule

// File: tb/tb_deflect_port_allocator.sv
// tb/tb_deflect_port_allocator.sv - randomized and directed bench for deflect_port_allocator
module tb_deflect_port_allocator;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int AGE_MAX = 63;
  localparam int CNT_MAX = 65535;

  logic clk;
  logic rst_n;

  deflect_port_allocator_if #(.DATA_W(DW), .AGE_W(AW), .CNT_W(CW)) bus ();

  deflect_port_allocator #(.DATA_W(DW), .AGE_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  // Stimulus state, owned by the bench
  logic        tValid [4];
  int          tAge   [4];
  logic [4:0]  tProd  [4];
  logic [31:0] tData  [4];
  logic        injReq;
  logic [4:0]  injProd;
  logic [31:0] injData;
  logic        deflClr;

  // Model state
  int   mRr = 0;
  logic mFree [5];
  int   mSrc  [5];
  logic mDefl [4];
  logic mAck;
  logic        expValid [5] = '{default: 1'b0};
  int          expAge   [5] = '{default: 0};
  logic [31:0] expData  [5] = '{default: 32'h0};
  logic        expDefl  [4] = '{default: 1'b0};
  int          expCnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end else begin
      nPass++;
    end
  endtask

  function automatic void placeOne(input int src, input logic [4:0] prod);
    int   p;
    logic d;
    p = -1;
    d = 1'b0;
    if (prod[4] && mFree[4]) p = 4;
    else begin
      for (int q = 0; q < 4; q++) if (p < 0 && prod[q] && mFree[q]) p = q;
      if (p < 0) begin
        d = 1'b1;
        for (int q = 0; q < 4; q++) if (p < 0 && mFree[q]) p = q;
      end
    end
    if (p >= 0) begin
      mFree[p] = 1'b0;
      mSrc[p]  = src;
      if (d) mDefl[p] = 1'b1;
    end
  endfunction

  // Oldest-first ranking by repeated selection, then greedy placement; injection placed last
  function automatic void modelAlloc();
    int   order[$];
    logic picked [4];
    int   best;
    logic anyNet;
    for (int p = 0; p < 5; p++) begin mFree[p] = 1'b1; mSrc[p] = -1; end
    for (int p = 0; p < 4; p++) begin mDefl[p] = 1'b0; picked[p] = 1'b0; end
    for (int n = 0; n < 4; n++) begin
      best = -1;
      for (int i = 0; i < 4; i++) begin
        if (tValid[i] && !picked[i]) begin
          if (best < 0 || tAge[i] > tAge[best] ||
              (tAge[i] == tAge[best] && ((i - mRr + 4) % 4) < ((best - mRr + 4) % 4)))
            best = i;
        end
      end
      if (best >= 0) begin picked[best] = 1'b1; order.push_back(best); end
    end
    foreach (order[k]) placeOne(order[k], tProd[order[k]]);
    anyNet = mFree[0] | mFree[1] | mFree[2] | mFree[3];
    mAck = rst_n && injReq && anyNet;
    if (mAck) placeOne(4, injProd);
  endfunction

  // Model of the registered stage
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 5; p++) begin expValid[p] = 1'b0; expAge[p] = 0; expData[p] = 32'h0; end
      for (int p = 0; p < 4; p++) expDefl[p] = 1'b0;
      expCnt = 0;
      mRr = 0;
    end else begin
      int pop;
      int nv;
      modelAlloc();
      pop = 0;
      nv  = 0;
      for (int p = 0; p < 5; p++) begin
        expValid[p] = (mSrc[p] >= 0);
        if (mSrc[p] == 4) begin
          expAge[p] = 1; expData[p] = injData;
        end else if (mSrc[p] >= 0) begin
          expAge[p]  = (tAge[mSrc[p]] + 1 > AGE_MAX) ? AGE_MAX : tAge[mSrc[p]] + 1;
          expData[p] = tData[mSrc[p]];
        end else begin
          expAge[p] = 0; expData[p] = 32'h0;
        end
      end
      for (int p = 0; p < 4; p++) begin expDefl[p] = mDefl[p]; pop += int'(mDefl[p]); end
      expCnt = deflClr ? 0 : ((expCnt + pop > CNT_MAX) ? CNT_MAX : expCnt + pop);
      for (int i = 0; i < 4; i++) nv += int'(tValid[i]);
      if (nv >= 2) mRr = (mRr + 1) % 4;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    logic [4:0] ev;
    logic [3:0] ed;
    modelAlloc();
    chk("inj_ack", 64'(bus.inj_ack), 64'(mAck));
    for (int p = 0; p < 5; p++) ev[p] = expValid[p];
    for (int p = 0; p < 4; p++) ed[p] = expDefl[p];
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("out_deflect", 64'(bus.out_deflect), 64'(ed));
    chk("defl_cnt", 64'(bus.defl_cnt), 64'(expCnt));
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("out_age[%0d]", p), 64'(bus.out_age[p*AW +: AW]), 64'(expAge[p]));
      chk($sformatf("out_data[%0d]", p), 64'(bus.out_data[p*DW +: DW]), 64'(expData[p]));
    end
  end

  task automatic drive();
    logic [3:0]   v;
    logic [23:0]  a;
    logic [19:0]  pr;
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      v[i]          = tValid[i];
      a[i*AW +: AW] = AW'(tAge[i]);
      pr[i*5 +: 5]  = tProd[i];
      d[i*DW +: DW] = tData[i];
    end
    bus.in_valid = v;
    bus.in_age   = a;
    bus.in_prod  = pr;
    bus.in_data  = d;
    bus.inj_req  = injReq;
    bus.inj_prod = injProd;
    bus.inj_data = injData;
    bus.defl_clr = deflClr;
  endtask

  task automatic clearIn();
    for (int i = 0; i < 4; i++) begin tValid[i] = 1'b0; tAge[i] = 0; tProd[i] = 5'b0; tData[i] = 32'h0; end
    injReq = 1'b0; injProd = 5'b0; injData = 32'h0; deflClr = 1'b0;
  endtask

  task automatic setFlit(input int i, input int age, input logic [4:0] prod, input logic [31:0] data);
    tValid[i] = 1'b1; tAge[i] = age; tProd[i] = prod; tData[i] = data;
  endtask

  task automatic randIn();
    for (int i = 0; i < 4; i++) begin
      tValid[i] = ($urandom_range(0, 3) != 0);
      tAge[i]   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
      tProd[i]  = 5'($urandom);
      tData[i]  = $urandom;
    end
    injReq  = ($urandom_range(0, 1) != 0);
    injProd = 5'($urandom);
    injData = $urandom;
    deflClr = ($urandom_range(0, 31) == 0);
  endtask

  // Advance one cycle: outputs of the current inputs are visible at the next falling edge
  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    clearIn();
    drive();
    #1 rst_n = 1'b0;
    injReq = 1'b1;
    setFlit(0, 5, 5'b00001, 32'h11);
    drive();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_defl_cnt", 64'(bus.defl_cnt), 64'h0);
    chk("rst_inj_ack", 64'(bus.inj_ack), 64'h0);

    // Equal ages on inputs 1 and 3, tie pointer 0, 1, 2
    clearIn();
    setFlit(1, 4, 5'b01000, 32'hA1);
    setFlit(3, 4, 5'b01000, 32'hA3);
    drive();
    rst_n = 1'b1;
    settle();
    chk("tie0_valid", 64'(bus.out_valid), 64'b01001);
    chk("tie0_defl", 64'(bus.out_deflect), 64'b0001);
    chk("tie0_win", 64'(bus.out_data[3*DW +: DW]), 64'hA1);
    chk("tie0_age", 64'(bus.out_age[3*AW +: AW]), 64'd5);
    #1 settle();
    chk("tie1_win", 64'(bus.out_data[3*DW +: DW]), 64'hA1);
    #1 settle();
    chk("tie2_win", 64'(bus.out_data[3*DW +: DW]), 64'hA3);
    chk("tie2_loser", 64'(bus.out_data[0*DW +: DW]), 64'hA1);
    chk("tie2_cnt", 64'(bus.defl_cnt), 64'd3);

    // Single productive flit
    #1 clearIn();
    setFlit(0, 3, 5'b00010, 32'hB0);
    drive();
    settle();
    chk("single_valid", 64'(bus.out_valid), 64'b00010);
    chk("single_age", 64'(bus.out_age[1*AW +: AW]), 64'd4);
    chk("single_defl", 64'(bus.out_deflect), 64'b0000);
    chk("single_cnt", 64'(bus.defl_cnt), 64'd3);

    // Contention for port 0
    #1 clearIn();
    setFlit(0, 9, 5'b00001, 32'hC0);
    setFlit(2, 5, 5'b00001, 32'hC2);
    drive();
    settle();
    chk("cont_valid", 64'(bus.out_valid), 64'b00011);
    chk("cont_defl", 64'(bus.out_deflect), 64'b0010);
    chk("cont_port1", 64'(bus.out_data[1*DW +: DW]), 64'hC2);
    chk("cont_cnt", 64'(bus.defl_cnt), 64'd4);

    // Two ejecting flits
    #1 clearIn();
    setFlit(0, 2, 5'b10000, 32'hD0);
    setFlit(1, 7, 5'b10000, 32'hD1);
    drive();
    settle();
    chk("eject_valid", 64'(bus.out_valid), 64'b10001);
    chk("eject_data", 64'(bus.out_data[4*DW +: DW]), 64'hD1);
    chk("eject_age", 64'(bus.out_age[4*AW +: AW]), 64'd8);
    chk("eject_defl", 64'(bus.out_deflect), 64'b0001);

    // Injection into the one remaining network port
    #1 clearIn();
    setFlit(0, 1, 5'b00001, 32'hE0);
    setFlit(1, 1, 5'b00010, 32'hE1);
    setFlit(2, 1, 5'b00100, 32'hE2);
    injReq = 1'b1; injProd = 5'b01000; injData = 32'hE4;
    drive();
    #1 chk("inj_ack3", 64'(bus.inj_ack), 64'd1);
    settle();
    chk("inj_valid", 64'(bus.out_valid), 64'b01111);
    chk("inj_data", 64'(bus.out_data[3*DW +: DW]), 64'hE4);
    chk("inj_age", 64'(bus.out_age[3*AW +: AW]), 64'd1);
    chk("inj_defl", 64'(bus.out_deflect), 64'b0000);

    // Four flits block injection; age 63 saturates
    #1 clearIn();
    setFlit(0, 63, 5'b00001, 32'hF0);
    setFlit(1, 0, 5'b00001, 32'hF1);
    setFlit(2, 0, 5'b00001, 32'hF2);
    setFlit(3, 0, 5'b00001, 32'hF3);
    injReq = 1'b1; injProd = 5'b01000;
    drive();
    #1 chk("inj_ack4", 64'(bus.inj_ack), 64'd0);
    settle();
    chk("sat_age", 64'(bus.out_age[0*AW +: AW]), 64'd63);
    chk("full_defl", 64'(bus.out_deflect), 64'b1110);
    chk("full_cnt", 64'(bus.defl_cnt), 64'd8);

    // Clear wins over concurrent deflections
    #1 deflClr = 1'b1;
    drive();
    settle();
    chk("clr_cnt", 64'(bus.defl_cnt), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      #1 randIn();
      drive();
      settle();
    end

    // Reset in the middle of traffic clears outputs without a clock edge
    #1 randIn();
    injReq = 1'b1;
    drive();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_defl", 64'(bus.out_deflect), 64'h0);
    chk("midrst_cnt", 64'(bus.defl_cnt), 64'h0);
    chk("midrst_ack", 64'(bus.inj_ack), 64'h0);
    repeat (2) settle();
    #1 rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      #1 randIn();
      drive();
      settle();
    end

    #1;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/deflect_port_allocator.md
Name: deflect_port_allocator

Overview:
- Per-router output-port allocator for the bufferless deflection router.
- Takes up to four network flits, each with the 5-bit productive vector from its route-computation block, plus one local injection request.
- Assigns every flit to a distinct output port in oldest-first order. Flits that find no free productive port are deflected.
- Registers the assignment, giving a 1-cycle router stage, and keeps a saturating deflection counter.

Parameters:
- DATA_W, 32, opaque flit payload width carried unchanged.
- AGE_W, 6, flit age field width.
- CNT_W, 16, deflection counter width.

Ports:
- clk  in  1  router clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  4  flit present on input i (0=W, 1=E, 2=S, 3=N)
- in_age  in  4*AGE_W  age of flit i, slice i
- in_prod  in  4*5  productive vector of flit i (bit0 W, 1 E, 2 S, 3 N, 4 local)
- in_data  in  4*DATA_W  payload of flit i
- inj_req  in  1  local core has a flit to inject
- inj_prod  in  5  productive vector of the injection flit
- inj_data  in  DATA_W  injection payload
- inj_ack  out  1  injection accepted this cycle (combinational)
- out_valid  out  5  registered valid per output port (bit4 = eject)
- out_age  out  5*AGE_W  registered age per output
- out_data  out  5*DATA_W  registered payload per output
- out_deflect  out  4  registered; flit on network output j was deflected
- defl_cnt  out  CNT_W  saturating count of deflected flits
- defl_clr  in  1  synchronous clear of defl_cnt

Behaviour:
- Reset (rst_n low, asynchronous): all out_valid=0, out_deflect=0, out_age/out_data=0, defl_cnt=0, tie pointer rr_ptr=0. inj_ack is 0 while in reset.
- Priority order:
  - Valid flits are ranked by age, larger first.
  - Equal ages are ranked by input index rotated from rr_ptr: index rr_ptr first, then rr_ptr+1 mod 4, and so on.
  - rr_ptr advances by 1 (mod 4) at every clock edge where at least 2 inputs are valid; otherwise it holds.
- Allocation walks flits in rank order against a free-port mask, initially all 5 ports free:
  - Eject: a flit with prod bit4 set takes port 4 if it is free. Only the first such flit ejects.
  - Productive: otherwise the flit takes the lowest-index free port among prod[3:0].
  - Deflect: if none of its productive ports is free, it takes the lowest-index free network port (0..3) and is marked deflected.
  - Bit4 excluded: port 4 is never used for deflection. A flit whose only productive bit is bit4, when port 4 is taken, is deflected.
  - Four flits always fit on four network ports, so no flit is ever dropped.
- Injection:
  - inj_ack=1 iff inj_req=1 and, after allocating all network flits, at least one network port (0..3) is free. The injection flit may also take port 4 when inj_prod bit4 is set and port 4 is still free.
  - The injection flit is allocated last, by the same productive-then-deflect rule, with age 0.
  - Being allocated last means injection never displaces a network flit. With 4 valid inputs, inj_ack=0.
- Output registration:
  - Winners are registered on the next rising clk edge: out_valid, out_data, and out_age = min(age+1, 2^AGE_W-1), saturating.
  - Ports not assigned a flit register out_valid=0; age and data are don't-care but held at 0.
- Latency: exactly 1 cycle input-to-output; no backpressure exists in the network.
- defl_cnt:
  - Adds popcount(deflections this cycle) each edge and saturates at 2^CNT_W-1.
  - defl_clr has priority over increment; the cleared cycle counts 0.
- Invalid prod vector:
  - An all-zero in_prod on a valid flit is treated as "no productive port", so the flit is deflected.
  - Any bit4 combined with other bits follows the eject rule first.
- Invalid inputs (in_valid bit 0) are ignored entirely, whatever their age, prod or data.

Decomposition:
- Shared package/header holds:
  - port index constants (W=0, E=1, S=2, N=3, LOCAL=4) and NUM_PORT=5;
  - flit field widths;
  - the age-saturate function.
- One sub-module, age_rank_sorter: a combinational 4-input sorter yielding the rank order from ages and rr_ptr. The allocation chain and registers remain in the top module.

Test Plan:
- Single flit, in_valid=0001, age=3, prod=00010 -> next cycle out_valid=00010, out_age[1]=4, out_deflect=0, defl_cnt unchanged.
- Contention:
  - Stimulus: flits 0 (age 9) and 2 (age 5), both prod=00001.
  - Flit 0 -> port 0; flit 2 deflected to port 1.
  - out_deflect=0010; defl_cnt +1.
- Equal ages:
  - Stimulus: age 4 on inputs 1 and 3, both prod=01000, rr_ptr=0.
  - Flit 1 wins port 3, flit 3 deflected to port 0.
  - Next cycle, same stimulus with rr_ptr=1: flit 1 wins again.
  - With rr_ptr=2 (or 3): flit 3 wins.
- Double eject:
  - Stimulus: two flits with prod=10000, ages 7 and 2.
  - Age-7 flit -> out_valid[4]; age-2 flit deflected to port 0.
- Injection:
  - 3 valid inputs on ports 0,1,2 productive; inj_req=1, inj_prod=01000 -> inj_ack=1 and injection flit appears on port 3 with out_age=1.
  - With 4 valid inputs -> inj_ack=0.
- Reset and saturation:
  - Input age=63 -> out_age=63.
  - Assert rst_n=0 mid-traffic -> outputs clear immediately without a clock; defl_cnt=0.
  - defl_clr with a concurrent deflection -> defl_cnt=0.
